// File: rtl/midi_uart_tx_pkg.sv
// Shared definitions for the MIDI transmit path: FSM states, line rate and
// status-byte classification helpers.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } midi_tx_state_t;

    localparam int MIDI_BAUD = 31_250;

    localparam logic [7:0] STATUS_MIN = 8'h80;
    localparam logic [7:0] SYSCOM_MIN = 8'hF0;
    localparam logic [7:0] RT_MIN     = 8'hF8;

    function automatic logic is_status(input logic [7:0] b);
        return b >= STATUS_MIN;
    endfunction

    // Channel voice/mode status bytes are the only ones eligible for running status
    function automatic logic is_channel_status(input logic [7:0] b);
        return is_status(b) && (b < SYSCOM_MIN);
    endfunction

    function automatic logic is_syscom(input logic [7:0] b);
        return (b >= SYSCOM_MIN) && (b < RT_MIN);
    endfunction

endpackage

// File: rtl/midi_uart_tx_if.sv
// Byte handshake between the synth core (master) and the MIDI transmitter (slave).
interface midi_uart_tx_if;

    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/midi_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 and flags the last cycle of each bit.
module midi_baud_tick #(
    parameter int DIV = 1600
) (
    input  logic clock,
    input  logic clear,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (restart || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI OUT serialiser: 8N1 frames at the MIDI line rate, fed by a valid/ready
// byte handshake, with optional running-status suppression of repeated status bytes.
module midi_uart_tx #(
    parameter int CLOCK_HZ       = 50_000_000,
    parameter int BAUD           = midi_pkg::MIDI_BAUD,
    parameter bit RUNNING_STATUS = 1'b0
) (
    input  logic           clock,
    input  logic           clear,
    midi_uart_tx_if.slave  bus,
    output logic           tx,
    output logic           busy
);

    import midi_pkg::*;

    localparam int DIV = CLOCK_HZ / BAUD;

    if (DIV < 2) begin : g_bad_div
        $error("midi_uart_tx: CLOCK_HZ/BAUD must be at least 2");
    end

    midi_tx_state_t state;
    logic [7:0]     shift;
    logic [2:0]     bit_idx;
    logic [7:0]     stored;
    logic           stored_ok;
    logic           ready_q;
    logic           tick;
    logic           suppress;

    // The timer is held at zero while idle so each frame starts on a fresh bit period
    midi_baud_tick #(.DIV(DIV)) u_tick (
        .clock   (clock),
        .clear   (clear),
        .restart (state == IDLE),
        .tick    (tick)
    );

    assign suppress = RUNNING_STATUS && stored_ok &&
                      is_channel_status(bus.data) && (bus.data == stored);

    assign bus.ready = ready_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            tx        <= 1'b1;
            ready_q   <= 1'b1;
            busy      <= 1'b0;
            shift     <= '0;
            bit_idx   <= '0;
            stored    <= '0;
            stored_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        if (!suppress) begin
                            shift   <= bus.data;
                            state   <= START;
                            tx      <= 1'b0;
                            ready_q <= 1'b0;
                            busy    <= 1'b1;
                        end
                        if (RUNNING_STATUS) begin
                            if (is_channel_status(bus.data)) begin
                                stored    <= bus.data;
                                stored_ok <= 1'b1;
                            end else if (is_syscom(bus.data)) begin
                                stored_ok <= 1'b0;
                            end
                        end
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                // tx is registered, so the next bit is taken from shift[1] before the shift lands
                DATA: begin
                    if (tick) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx at DIV=16: one instance without and one with
// running status, driven from a vector table plus back-to-back and clear sequences.
module tb_midi_uart_tx;

    import midi_pkg::*;

    localparam int DIV = 16;

    localparam logic [9:0] F90  = 10'b1_1001_0000_0;
    localparam logic [9:0] F3C  = 10'b1_0011_1100_0;
    localparam logic [9:0] F64  = 10'b1_0110_0100_0;
    localparam logic [9:0] F3E  = 10'b1_0011_1110_0;
    localparam logic [9:0] F40  = 10'b1_0100_0000_0;
    localparam logic [9:0] FF0  = 10'b1_1111_0000_0;
    localparam logic [9:0] FF8  = 10'b1_1111_1000_0;
    localparam logic [9:0] FF2  = 10'b1_1111_0010_0;
    localparam logic [9:0] F00  = 10'b1_0000_0000_0;
    localparam logic [9:0] FFF  = 10'b1_1111_1111_0;
    localparam logic [9:0] FA5  = 10'b1_1010_0101_0;
    localparam logic [9:0] F55  = 10'b1_0101_0101_0;
    localparam logic [9:0] IDLE_LINE = 10'b11_1111_1111;

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic       skip;
        logic [9:0] frame;
    } vec_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    logic sel   = 1'b0;
    logic tx0, tx1, busy0, busy1;
    logic tx_s, busy_s, ready_s;

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs[$];

    midi_uart_tx_if if0 ();
    midi_uart_tx_if if1 ();

    midi_uart_tx #(.CLOCK_HZ(500_000), .BAUD(31_250), .RUNNING_STATUS(1'b0)) dut0 (
        .clock (clock),
        .clear (clear),
        .bus   (if0),
        .tx    (tx0),
        .busy  (busy0)
    );

    midi_uart_tx #(.CLOCK_HZ(500_000), .BAUD(31_250), .RUNNING_STATUS(1'b1)) dut1 (
        .clock (clock),
        .clear (clear),
        .bus   (if1),
        .tx    (tx1),
        .busy  (busy1)
    );

    always #5 clock = ~clock;

    assign tx_s    = sel ? tx1       : tx0;
    assign busy_s  = sel ? busy1     : busy0;
    assign ready_s = sel ? if1.ready : if0.ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one byte to the selected instance for exactly one clock edge
    task automatic applyStimulus(input logic s, input logic [7:0] d);
        sel      = s;
        if0.data = d;
        if1.data = d;
        if (s) if1.valid = 1'b1;
        else   if0.valid = 1'b1;
        @(posedge clock); #1;
        if0.valid = 1'b0;
        if1.valid = 1'b0;
    endtask

    // Called one step after the accepting edge; walks the whole frame bit by bit
    task automatic checkOutput(input logic skip, input logic [9:0] frame, input string name);
        logic ok;
        ok = 1'b1;
        if (skip) begin
            check({name, " ready kept"}, ready_s, 1'b1);
            check({name, " busy low"}, busy_s, 1'b0);
            for (int j = 0; j < 2 * DIV; j++) begin
                if (tx_s !== 1'b1 || busy_s !== 1'b0 || ready_s !== 1'b1) ok = 1'b0;
                @(posedge clock); #1;
            end
            check({name, " line idle"}, ok, 1'b1);
        end else begin
            for (int k = 0; k < 10; k++) begin
                logic seen;
                seen = frame[k];
                for (int j = 0; j < DIV; j++) begin
                    if (tx_s !== frame[k]) seen = tx_s;
                    if (busy_s !== 1'b1 || ready_s !== 1'b0) ok = 1'b0;
                    @(posedge clock); #1;
                end
                check($sformatf("%s bit%0d", name, k), seen, frame[k]);
            end
            check({name, " busy/ready in frame"}, ok, 1'b1);
            check({name, " ready after"}, ready_s, 1'b1);
            check({name, " busy after"}, busy_s, 1'b0);
            check({name, " tx after"}, tx_s, 1'b1);
        end
    endtask

    initial begin
        logic idle_ok;

        if0.valid = 1'b0;
        if1.valid = 1'b0;
        if0.data  = 8'h00;
        if1.data  = 8'h00;

        vecs.push_back('{1'b0, 8'h90, 1'b0, F90});
        vecs.push_back('{1'b0, 8'h90, 1'b0, F90});
        vecs.push_back('{1'b0, 8'h00, 1'b0, F00});
        vecs.push_back('{1'b0, 8'hFF, 1'b0, FFF});
        vecs.push_back('{1'b0, 8'hA5, 1'b0, FA5});
        vecs.push_back('{1'b1, 8'h90, 1'b0, F90});
        vecs.push_back('{1'b1, 8'h3C, 1'b0, F3C});
        vecs.push_back('{1'b1, 8'h64, 1'b0, F64});
        vecs.push_back('{1'b1, 8'h90, 1'b1, IDLE_LINE});
        vecs.push_back('{1'b1, 8'h3E, 1'b0, F3E});
        vecs.push_back('{1'b1, 8'h40, 1'b0, F40});
        vecs.push_back('{1'b1, 8'hF0, 1'b0, FF0});
        vecs.push_back('{1'b1, 8'h90, 1'b0, F90});
        vecs.push_back('{1'b1, 8'hF8, 1'b0, FF8});
        vecs.push_back('{1'b1, 8'h90, 1'b1, IDLE_LINE});
        vecs.push_back('{1'b1, 8'hF2, 1'b0, FF2});
        vecs.push_back('{1'b1, 8'h90, 1'b0, F90});

        #22 clear = 1'b0;
        $display("[TB] reset released");

        idle_ok = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clock); #1;
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.ready !== 1'b1) idle_ok = 1'b0;
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || if1.ready !== 1'b1) idle_ok = 1'b0;
        end
        check("reset idle 200 cycles", idle_ok, 1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sel, vecs[i].data);
            checkOutput(vecs[i].skip, vecs[i].frame,
                        $sformatf("vec%0d rs%0d %02h", i, vecs[i].sel, vecs[i].data));
        end

        $display("[TB] back-to-back with valid held");
        sel       = 1'b0;
        if0.data  = 8'h3C;
        if0.valid = 1'b1;
        @(posedge clock); #1;
        if0.data  = 8'h64;
        checkOutput(1'b0, F3C, "b2b first 3C");
        @(posedge clock); #1;
        if0.valid = 1'b0;
        checkOutput(1'b0, F64, "b2b second 64");

        $display("[TB] clear during data bit 3");
        applyStimulus(1'b1, 8'h55);
        repeat (DIV * 4 + 6) @(posedge clock);
        #1;
        check("pre-clear tx is d3", tx_s, 1'b0);
        #2 clear = 1'b1;
        #1;
        check("clear tx async", tx_s, 1'b1);
        check("clear ready async", ready_s, 1'b1);
        check("clear busy async", busy_s, 1'b0);
        repeat (3) @(posedge clock);
        #3 clear = 1'b0;
        @(posedge clock); #1;
        check("post-clear ready", ready_s, 1'b1);
        check("post-clear busy", busy_s, 1'b0);
        check("post-clear tx", tx_s, 1'b1);
        applyStimulus(1'b1, 8'h90);
        checkOutput(1'b0, F90, "post-clear 90 status forgotten");
        applyStimulus(1'b1, 8'h55);
        checkOutput(1'b0, F55, "post-clear 55 full frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
